// File: rtl/reg_dump_reader.sv
// Scans a register bank through its read port and formats each address/value
// pair for an eight-digit HEX display, with auto-dwell or push-button stepping.
module reg_dump_reader #(
  parameter int NREG   = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int DWELL  = 25000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              step_mode,
  input  logic              next,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [31:0]       display,
  output logic [7:0]        modo,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(NREG - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [7:0]        MODO_SHOW = 8'b1100_1111;

  typedef enum logic [2:0] {IDLE, REQ, CAPTURE, SHOW, FINISH} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [31:0]       display_n;
  logic [7:0]        modo_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [15:0]       data16;
  logic              leave;

  // Narrow banks zero-extend, wide banks show only the low 16 bits.
  assign data16 = 16'(rd_data);

  assign rd_en = (state == REQ);
  assign busy  = (state != IDLE);
  assign done  = (state == FINISH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rd_addr <= '0;
      display <= '0;
      modo    <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      rd_addr <= addr_n;
      display <= display_n;
      modo    <= modo_n;
      cnt     <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    addr_n    = rd_addr;
    display_n = display;
    modo_n    = modo;
    cnt_n     = cnt;
    leave     = 1'b0;
    if (abort && state != IDLE) begin
      // Blank the digits; a capture in flight is simply never taken.
      state_n = IDLE;
      addr_n  = '0;
      modo_n  = '0;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            state_n = REQ;
            addr_n  = '0;
          end
        end
        REQ: state_n = CAPTURE;
        CAPTURE: begin
          display_n = {8'(rd_addr), 8'h00, data16};
          modo_n    = MODO_SHOW;
          cnt_n     = '0;
          state_n   = SHOW;
        end
        SHOW: begin
          // Counter freezes while stepping so a switch to auto resumes cleanly.
          if (step_mode) begin
            leave = next;
          end else if (cnt >= CNT_LAST) begin
            leave = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
          if (leave) begin
            if (rd_addr == LAST) begin
              state_n = FINISH;
            end else begin
              addr_n  = rd_addr + 1'b1;
              state_n = REQ;
            end
          end
        end
        FINISH: begin
          state_n = IDLE;
          addr_n  = '0;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench: stimulus queues the reads/done pulses a scan must produce,
// a negedge monitor pops and compares as the DUT strobes rd_en and done.
module tb_reg_dump_reader;
  localparam int NREG = 16, ADDR_W = 4, DATA_W = 16, DWELL = 4;
  localparam int PER = DWELL + 2;

  logic clk = 0, reset = 1, start = 0, abort = 0, step_mode = 0, next = 0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [31:0]       display;
  logic [7:0]        modo;
  logic              busy, done;

  reg_dump_reader #(.NREG(NREG), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DWELL(DWELL)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .step_mode(step_mode),
    .next(next), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .display(display), .modo(modo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    int          addr;
    logic [31:0] disp;
    int          cyc;   // -1: timing not predicted
  } exp_t;

  exp_t        sb[$];
  logic [15:0] bank [NREG];
  int          cyc = 0, n_cmp = 0, n_bad = 0;

  // Bank read port: data one cycle after rd_en, noise otherwise.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_data <= rd_en ? bank[rd_addr] : DATA_W'($urandom);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] disp_of(input int k);
    return {8'(k), 8'h00, bank[k]};
  endfunction

  task automatic push_read(input int k, input int c);
    exp_t e;
    e.is_done = 0; e.addr = k; e.disp = disp_of(k); e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic push_done(input int c);
    exp_t e;
    e.is_done = 1; e.addr = 0; e.disp = '0; e.cyc = c;
    sb.push_back(e);
  endtask

  // Auto mode: reg k strobed PER cycles apart, done PER after the last strobe.
  task automatic push_auto(input int s);
    for (int k = 0; k < NREG; k++) push_read(k, s + 1 + k * PER);
    push_done(s + 1 + NREG * PER);
  endtask

  task automatic fill(input bit rnd);
    for (int k = 0; k < NREG; k++) bank[k] = rnd ? 16'($urandom) : 16'h1000 + 16'(k);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard drained", sb.size(), 0);
    sb.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, " rd_en"}, 32'(rd_en), 0);
    check({tag, " rd_addr"}, 32'(rd_addr), 0);
    check({tag, " display"}, display, 0);
    check({tag, " modo"}, 32'(modo), 0);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " done"}, 32'(done), 0);
  endtask

  task automatic auto_scan(input bit with_next);
    int s, d;
    s = cyc;
    push_auto(s);
    d = s + 1 + NREG * PER;
    start = 1;
    @(negedge clk);
    start = 0;
    while (cyc < d) begin
      next = with_next && ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    next = 0;
    @(negedge clk);
    check("busy after done", 32'(busy), 0);
    check("scan drained", sb.size(), 0);
  endtask

  // Monitor
  bit          pend_on = 0;
  int          pend_at;
  logic [31:0] pend_disp;
  exp_t        me;

  always @(negedge clk) begin
    if (reset) begin
      pend_on = 0;
    end else begin
      if (pend_on && cyc == pend_at) begin
        check("display", display, pend_disp);
        check("modo", 32'(modo), 32'hCF);
        pend_on = 0;
      end
      if (rd_en) begin
        if (sb.size() == 0 || sb[0].is_done) begin
          check("rd_en while none expected", 32'(rd_en), 0);
        end else begin
          me = sb.pop_front();
          check("rd_addr", 32'(rd_addr), me.addr);
          if (me.cyc >= 0) check("rd_en cycle", cyc, me.cyc);
          pend_on   = 1;
          pend_at   = cyc + 2;
          pend_disp = me.disp;
        end
      end
      if (done) begin
        if (sb.size() == 0 || !sb[0].is_done) begin
          check("done while none expected", 32'(done), 0);
        end else begin
          me = sb.pop_front();
          if (me.cyc >= 0) check("done cycle", cyc, me.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, c5, d1, d2;
    fill(0);
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 0;
    @(negedge clk);

    // Known pattern, stray next pulses in auto mode must not matter.
    auto_scan(1);
    fill(1); auto_scan(0);
    fill(1); auto_scan(1);

    // Step mode: hold on reg 0, then three next pulses.
    fill(1);
    step_mode = 1;
    s = cyc;
    push_read(0, s + 1);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_cyc(s + 101);
    check("step hold display", display, disp_of(0));
    check("step hold rd_addr", 32'(rd_addr), 0);
    for (int k = 1; k <= 3; k++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      push_read(k, cyc + 1);
      next = 1;
      @(negedge clk);
      next = 0;
      repeat (2) @(negedge clk);
    end
    check("step display reg3", display, disp_of(3));
    check("step rd_addr", 32'(rd_addr), 3);
    for (int k = 4; k < NREG; k++) push_read(k, -1);
    push_done(-1);
    step_mode = 0;
    drain(NREG * PER + 20);
    @(negedge clk);
    check("busy after step scan", 32'(busy), 0);

    // Abort while showing reg 5.
    fill(1);
    s = cyc;
    for (int k = 0; k <= 5; k++) push_read(k, s + 1 + k * PER);
    start = 1;
    @(negedge clk);
    start = 0;
    c5 = s + 1 + 5 * PER;
    wait_cyc(c5 + 2);
    abort = 1;
    @(negedge clk);
    check("abort modo", 32'(modo), 0);
    check("abort rd_addr", 32'(rd_addr), 0);
    check("abort busy", 32'(busy), 0);
    check("abort done", 32'(done), 0);
    start = 1;
    repeat (4) begin
      @(negedge clk);
      check("start+abort busy", 32'(busy), 0);
      check("start+abort rd_en", 32'(rd_en), 0);
    end
    start = 0;
    abort = 0;
    @(negedge clk);
    check("abort queue", sb.size(), 0);

    // Async reset during CAPTURE, then a full rescan.
    fill(1);
    s = cyc;
    push_read(0, s + 1);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_cyc(s + 2);
    #2 reset = 1;
    #1 check_zero("async reset");
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    check("reset queue", sb.size(), 0);
    fill(1); auto_scan(0);

    // start held high: back-to-back scans with one IDLE cycle between.
    fill(1);
    s = cyc;
    push_auto(s);
    d1 = s + 1 + NREG * PER;
    push_auto(d1 + 1);
    d2 = d1 + 2 + NREG * PER;
    start = 1;
    wait_cyc(d1 + 3);
    start = 0;
    wait_cyc(d2 + 1);
    check("busy after second scan", 32'(busy), 0);
    repeat (3) @(negedge clk);
    check("no third scan", 32'(busy), 0);

    check("final queue", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
